// File: rtl/ledport_seq_fta32.sv
// ledport_seq_fta32: FTA32 bus master that plays a programmable LED pattern
//   table to the LED port, one ERC write per step, at a prescaled tick rate.
// Latency: step_due -> cs/req asserted next cycle; minimum step period 3 clk.
// Backpressure: one write in flight; waits for a tid-matched ack or TIMEOUT.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   en                  run enable; a rising edge restarts at entry 0
//   tbl_we/adr/dat      pattern table write port (accepted in any state)
//   last                index of the final pattern entry (wrap point)
//   step_ticks          ticks per step, 0 behaves as 1
//   cs, req             LED port select and FTA32 request (registered)
//   resp                FTA32 response from the LED port
//   idx                 index of the entry most recently written
//   busy                write in flight
//   err                 sticky ack-timeout flag, cleared only by reset

package ledport_seq_fta32_pkg;

  // Cycle type identifier for a single-beat (ERC) transfer.
  localparam logic [2:0] CTI_ERC = 3'b011;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] padr;
    logic [31:0] dat;
    logic [12:0] tid;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic        ack;
    logic [12:0] tid;
  } fta_cmd_response32_t;

endpackage

module ledport_seq_fta32
  import ledport_seq_fta32_pkg::*;
#(
  parameter int unsigned  DEPTH    = 16,
  parameter int unsigned  PRESCALE = 1000,
  parameter logic [31:0]  LED_ADR  = 32'hFEDC0000,
  parameter int unsigned  TIMEOUT  = 64,
  parameter logic [12:0]  TID_BASE = 13'h0100,
  localparam int unsigned IW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tbl_we,
  input  logic [IW-1:0]       tbl_adr,
  input  logic [7:0]          tbl_dat,
  input  logic [IW-1:0]       last,
  input  logic [15:0]         step_ticks,
  output logic                cs,
  output fta_cmd_request32_t  req,
  input  fta_cmd_response32_t resp,
  output logic [IW-1:0]       idx,
  output logic                busy,
  output logic                err
);

  localparam int unsigned   PW       = $clog2(PRESCALE);
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  // Pattern table
  logic [7:0]         tbl_q [DEPTH];

  // Rate generation
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick;
  logic [15:0]        tcnt_q, tcnt_d;
  logic [15:0]        step_lim;
  logic               step_fire;
  logic               step_due_q, step_due_d;
  logic               first_q, first_d;
  logic               consume;

  // Sequencer
  state_t             state_q;
  logic [IW-1:0]      nidx_c;
  logic [IW-1:0]      nidx_q;
  logic [IW-1:0]      idx_q;
  logic [TW-1:0]      tmo_q;
  logic [2:0]         seq_q;
  logic               cs_q;
  logic               busy_q;
  logic               err_q;
  fta_cmd_request32_t req_q;
  logic               ack_ok;

  assign cs   = cs_q;
  assign req  = req_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign err  = err_q;

  // ---------------------------------------------------------------------------
  // Pattern table. The in-flight req.dat is a registered copy, so rewriting the
  // entry currently being issued cannot disturb the bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_q[tbl_adr] <= tbl_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler, step counter and next-index selection
  // ---------------------------------------------------------------------------
  always_comb begin
    tick = en && (pre_q == PRE_LAST);

    pre_d = pre_q + 1'b1;
    if (!en || tick) begin
      pre_d = '0;
    end

    step_lim = (step_ticks == 16'd0) ? 16'd1 : step_ticks;

    // Compare with >= so that lowering step_ticks below the running count
    // fires on the next tick instead of waiting for a 16-bit wrap.
    step_fire = tick && (({1'b0, tcnt_q} + 17'd1) >= {1'b0, step_lim});

    // The tick count is discarded while disabled so a restart begins with a
    // full step period.
    tcnt_d = tcnt_q;
    if (!en || step_fire) begin
      tcnt_d = '0;
    end else if (tick) begin
      tcnt_d = tcnt_q + 16'd1;
    end

    consume = (state_q == S_IDLE) && step_due_q && en;

    // At most one step pending; a fire while one is pending merges into it.
    step_due_d = (step_due_q && !consume) || step_fire;
    if (!en) begin
      step_due_d = 1'b0;
    end

    // first_q marks "next write starts the pattern from entry 0".
    first_d = first_q;
    if (!en) begin
      first_d = 1'b1;
    end else if (consume) begin
      first_d = 1'b0;
    end

    if (first_q || (idx_q == last) || (idx_q == IDX_MAX)) begin
      nidx_c = '0;
    end else begin
      nidx_c = idx_q + 1'b1;
    end

    ack_ok = resp.ack && (resp.tid == req_q.tid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      tcnt_q     <= '0;
      step_due_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      pre_q      <= pre_d;
      tcnt_q     <= tcnt_d;
      step_due_q <= step_due_d;
      first_q    <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write sequencer with registered bus outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nidx_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      seq_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (consume) begin
            nidx_q       <= nidx_c;
            cs_q         <= 1'b1;
            busy_q       <= 1'b1;
            req_q.cyc    <= 1'b1;
            req_q.we     <= 1'b1;
            req_q.sel    <= 4'h1;
            req_q.cti    <= CTI_ERC;
            req_q.padr   <= LED_ADR;
            req_q.dat    <= {24'd0, tbl_q[nidx_c]};
            req_q.tid    <= TID_BASE | {10'd0, seq_q};
            state_q      <= S_REQ;
          end
        end

        S_REQ: begin
          tmo_q   <= TMO_LOAD;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          // A matching ack on the expiry edge still counts as success.
          if (ack_ok || (tmo_q == TMO_ONE)) begin
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= '0;
            idx_q   <= nidx_q;
            seq_q   <= seq_q + 3'd1;
            state_q <= S_IDLE;
            if (!ack_ok) begin
              err_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end

        default: begin
          cs_q    <= 1'b0;
          busy_q  <= 1'b0;
          req_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ledport_seq_fta32.sv
// tb_ledport_seq_fta32: scoreboard bench for the LED pattern sequencer.
// The driver predicts every write (entry, data, tid, timing) from the pattern
// rules and queues it; a bus monitor pops and compares as writes appear.
module tb_ledport_seq_fta32;
  import ledport_seq_fta32_pkg::*;

  localparam int          DEPTH    = 8;
  localparam int          PRESCALE = 4;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] LED_ADR  = 32'hFEDC0000;
  localparam logic [12:0] TID_BASE = 13'h0100;
  localparam int          M_TMO    = -1;  // responder never acks
  localparam int          M_MIS    = -2;  // wrong tid first, right tid 3 cycles later

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                en = 1'b0;
  logic                tbl_we = 1'b0;
  logic [2:0]          tbl_adr = '0;
  logic [7:0]          tbl_dat = '0;
  logic [2:0]          last = '0;
  logic [15:0]         step_ticks = '0;
  logic                cs;
  fta_cmd_request32_t  req;
  fta_cmd_response32_t resp = '0;
  logic [2:0]          idx;
  logic                busy;
  logic                err;

  ledport_seq_fta32 #(
    .DEPTH(DEPTH), .PRESCALE(PRESCALE), .LED_ADR(LED_ADR),
    .TIMEOUT(TIMEOUT), .TID_BASE(TID_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .tbl_we(tbl_we), .tbl_adr(tbl_adr), .tbl_dat(tbl_dat),
    .last(last), .step_ticks(step_ticks),
    .cs(cs), .req(req), .resp(resp),
    .idx(idx), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dat;
    int idx;
    int tid;
    int width;
    int err;
    bit first;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_q[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_cyc = 0;
  int   done_cnt = 0;
  int   rise_cnt = 0;
  bit   mon_off = 1'b0;

  // Reference model state
  int   tbl_m [DEPTH];
  int   last_m = 0;
  int   seq_m = 0;
  int   err_m = 0;
  int   prev_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // LED port responder
  // ---------------------------------------------------------------------------
  int rsp_c = 0;
  int rsp_mode = 0;
  always @(negedge clk) begin
    if (cs) begin
      if (rsp_c == 0) rsp_mode = (rsp_q.size() != 0) ? rsp_q.pop_front() : M_TMO;
      rsp_c++;
    end else begin
      rsp_c = 0;
    end
    resp = '0;
    if (cs) begin
      if (rsp_mode >= 0 && rsp_c == 2 + rsp_mode) begin
        resp.ack = 1'b1;
        resp.tid = req.tid;
      end
      if (rsp_mode == M_MIS && rsp_c == 2) begin
        resp.ack = 1'b1;
        resp.tid = req.tid ^ 13'h1;
      end
      if (rsp_mode == M_MIS && rsp_c == 5) begin
        resp.ack = 1'b1;
        resp.tid = req.tid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus monitor / scoreboard
  // ---------------------------------------------------------------------------
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   cs_prev = 1'b0;
  bit   busy_ok = 1'b1;
  bit   stable_ok = 1'b1;
  int   hi_cnt = 0;
  int   last_rise = 0;

  always @(negedge clk) begin
    if (cs && !cs_prev) rise_cnt++;
    if (mon_off) begin
      have_cur = 1'b0;
    end else begin
      if (cs && !cs_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", exp_q.size(), 1);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("req_cyc", req.cyc, 1);
          chk("req_we", req.we, 1);
          chk("req_sel", req.sel, 4'h1);
          chk("req_cti", req.cti, CTI_ERC);
          chk("req_padr", req.padr, LED_ADR);
          chk("req_dat", req.dat, cur.dat);
          chk("req_tid", req.tid, cur.tid);
          if (cur.first) chk("first_latency", cyc - en_cyc, cur.gap);
          else           chk("step_period", cyc - last_rise, cur.gap);
        end
        last_rise = cyc;
        hi_cnt    = 0;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
      end
      if (cs && have_cur) begin
        hi_cnt++;
        if (!busy) busy_ok = 1'b0;
        if (req.dat != 32'(cur.dat) || req.tid != 13'(cur.tid)) stable_ok = 1'b0;
      end
      if (!cs && cs_prev && have_cur) begin
        chk("cs_width", hi_cnt, cur.width);
        chk("busy_during", busy_ok, 1);
        chk("req_stable", stable_ok, 1);
        chk("idx_after", idx, cur.idx);
        chk("busy_after", busy, 0);
        chk("err_after", err, cur.err);
        done_cnt++;
        have_cur = 1'b0;
      end
    end
    cs_prev = cs;
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic set_tbl(int a, int d);
    @(negedge clk);
    tbl_we  = 1'b1;
    tbl_adr = 3'(a);
    tbl_dat = 8'(d);
    @(negedge clk);
    tbl_we  = 1'b0;
    tbl_m[a] = d & 8'hFF;
  endtask

  task automatic set_last(int v);
    last   = 3'(v);
    last_m = v;
  endtask

  // Predict one write: which entry, what it carries, how long cs stays up.
  task automatic predict(int e, int mode, bit first, int st);
    exp_t it;
    int   st1;
    st1      = (st == 0) ? 1 : st;
    it.dat   = tbl_m[e];
    it.idx   = e;
    it.tid   = int'(TID_BASE) | seq_m;
    it.width = (mode == M_TMO) ? TIMEOUT + 1 : (mode == M_MIS) ? 5 : 2 + mode;
    if (mode == M_TMO) err_m = 1;
    it.err   = err_m;
    it.first = first;
    it.gap   = first ? PRESCALE * st1 + 1 : PRESCALE * st1;
    seq_m    = (seq_m + 1) % 8;
    exp_q.push_back(it);
    rsp_q.push_back(mode);
  endtask

  task automatic wait_done(int tgt);
    int n;
    n = 0;
    while (done_cnt < tgt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("write_completed", done_cnt >= tgt, 1);
  endtask

  function automatic int next_entry(int e);
    return (e == last_m || e == DEPTH - 1) ? 0 : e + 1;
  endfunction

  task automatic do_write(int mode, bit first, int st, bit drop_en);
    int e, tgt, n;
    e = first ? 0 : next_entry(prev_e);
    predict(e, mode, first, st);
    tgt = done_cnt + 1;
    if (first) begin
      step_ticks = 16'(st);
      en = 1'b1;
      en_cyc = cyc;
    end
    if (drop_en) begin
      n = 0;
      while (rsp_c < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      en = 1'b0;
    end
    wait_done(tgt);
    prev_e = e;
  endtask

  task automatic phase_end();
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r0, n;
    for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_req_zero", (req == '0) ? 1 : 0, 1);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    r0 = rise_cnt;
    repeat (100) @(negedge clk);
    chk("idle_no_cs", rise_cnt - r0, 0);

    // Basic sequence: entries 0,1,2,0 every 8 cycles
    set_tbl(0, 8'h01);
    set_tbl(1, 8'h02);
    set_tbl(2, 8'h04);
    set_last(2);
    do_write(0, 1'b1, 2, 1'b0);
    repeat (3) do_write(0, 1'b0, 2, 1'b0);
    phase_end();

    // Wrap at last=0 with a table update between writes
    set_tbl(0, 8'hAA);
    set_last(0);
    do_write(0, 1'b1, 2, 1'b0);
    set_tbl(0, 8'h55);
    do_write(0, 1'b0, 2, 1'b0);
    phase_end();

    // step_ticks=0 behaves as 1: a write every PRESCALE cycles
    set_last(1);
    do_write(0, 1'b1, 0, 1'b0);
    repeat (2) do_write(0, 1'b0, 0, 1'b0);
    phase_end();

    // Timeout then a normal write; err stays set
    set_last(2);
    do_write(M_TMO, 1'b1, 4, 1'b0);
    do_write(1, 1'b0, 4, 1'b0);
    phase_end();

    // Mismatched tid ack is ignored
    do_write(M_MIS, 1'b1, 3, 1'b0);
    do_write(2, 1'b0, 3, 1'b0);
    phase_end();

    // en dropped mid-write: write completes, nothing further, restart at 0
    set_last(3);
    do_write(M_MIS, 1'b1, 3, 1'b1);
    r0 = rise_cnt;
    repeat (40) @(negedge clk);
    chk("en_drop_no_cs", rise_cnt - r0, 0);
    do_write(0, 1'b1, 3, 1'b0);
    do_write(3, 1'b0, 3, 1'b0);
    phase_end();

    // Randomized phases
    for (int p = 0; p < 6; p++) begin
      int st;
      st = $urandom_range(3, 4);
      n  = $urandom_range(3, 6);
      set_last($urandom_range(0, DEPTH - 1));
      repeat (2) set_tbl($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      for (int k = 0; k < n; k++) begin
        int rr, mode;
        if (k > 0) begin
          if ($urandom_range(0, 2) == 0) set_tbl($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) set_last($urandom_range(0, DEPTH - 1));
        end
        rr = $urandom_range(0, 9);
        if (st == 4 && rr == 0) mode = M_TMO;
        else if (rr == 1)       mode = M_MIS;
        else                    mode = $urandom_range(0, 3);
        do_write(mode, k == 0, st, 1'b0);
      end
      phase_end();
    end

    // Asynchronous reset in the middle of WAIT
    mon_off = 1'b1;
    rsp_q.push_back(M_TMO);
    step_ticks = 16'd2;
    en = 1'b1;
    n = 0;
    while (rsp_c < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_reached", rsp_c >= 3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs, 0);
    chk("arst_req_zero", (req == '0) ? 1 : 0, 1);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_idx", idx, 0);
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rsp_q.delete();
    r0 = rise_cnt;
    repeat (100) @(negedge clk);
    chk("post_rst_no_cs", rise_cnt - r0, 0);

    // Table, sequence number and err all restart from zero
    mon_off = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl_m[i] = 0;
    seq_m = 0;
    err_m = 0;
    set_last(0);
    do_write(0, 1'b1, 2, 1'b0);
    phase_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
